// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - shared types and constants for the score display scan controller
//
// Contents:
//   state_t         - scan sequencer states
//   SEG_OFF         - active-low all-segments-off pattern
//   SEG_DIGIT_0..9  - active-low 7-segment patterns, bit0=a ... bit6=g
//   MAX_DISPLAY     - largest value the two digits can show
//   saturate_score  - clamps a binary score to MAX_DISPLAY
package score_display_pkg;

    typedef enum logic [2:0] {
        S_LOAD,
        S_CONVERT,
        S_SCAN_TENS,
        S_BLANK_A,
        S_SCAN_ONES,
        S_BLANK_B
    } state_t;

    localparam logic [6:0] SEG_OFF     = 7'h7F;
    localparam logic [6:0] SEG_DIGIT_0 = 7'h40;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h79;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h24;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h30;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h19;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h12;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h02;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h78;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h00;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h10;

    localparam int MAX_DISPLAY = 99;

    // Radix step used by the repeated-subtract converter.
    localparam logic [6:0] CONV_STEP = 7'd10;

    // The caller zero-extends its score to 32 bits so any SCORE_WIDTH up
    // to 32 shares one comparison.
    function automatic logic [6:0] saturate_score(input logic [31:0] score);
        if (score > 32'(MAX_DISPLAY)) begin
            return 7'(MAX_DISPLAY);
        end
        return score[6:0];
    endfunction

endpackage

// File: rtl/score_display_scan_controller_decoder.sv
// rtl/score_display_scan_controller_decoder.sv - 4-bit to active-low 7-segment decoder
//
// Ports:
//   i_value    [3:0] - BCD digit; 10..15 decode to all segments off
//   o_segments [6:0] - active-low segment pattern, bit0=a ... bit6=g
module seg_digit_decoder
    import score_display_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [6:0] o_segments
);

    always_comb begin
        o_segments = SEG_OFF;
        case (i_value)
            4'd0:    o_segments = SEG_DIGIT_0;
            4'd1:    o_segments = SEG_DIGIT_1;
            4'd2:    o_segments = SEG_DIGIT_2;
            4'd3:    o_segments = SEG_DIGIT_3;
            4'd4:    o_segments = SEG_DIGIT_4;
            4'd5:    o_segments = SEG_DIGIT_5;
            4'd6:    o_segments = SEG_DIGIT_6;
            4'd7:    o_segments = SEG_DIGIT_7;
            4'd8:    o_segments = SEG_DIGIT_8;
            4'd9:    o_segments = SEG_DIGIT_9;
            default: o_segments = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/score_display_scan_controller.sv
// rtl/score_display_scan_controller.sv - two-digit multiplexed 7-segment score display scanner
//
// Snapshots the score once per frame, converts it to tens/ones by repeated
// subtraction of ten, then drives tens, a blank gap, ones and another blank
// gap on a shared active-low segment bus.
//
// Optional feature macro: SCORE_DISPLAY_LZB_EN (leading-zero blanking of
// the tens digit).
//
// Ports:
//   i_clk          - system clock
//   i_rst          - asynchronous active-high reset
//   i_score        - binary score, sampled once per frame in LOAD
//   i_blank        - forces all segments off (one cycle latency), scanning continues
//   o_segments     - active-low segments, bit0=a ... bit6=g
//   o_digit        - digit select, 0 = tens (left), 1 = ones (right)
//   o_frame_start  - one-cycle pulse after a new snapshot is latched
module score_display_scan_controller #(
    parameter int SCORE_WIDTH    = 7,
    parameter int CLKS_PER_DIGIT = 25000,
    parameter int BLANK_CLKS     = 250
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [SCORE_WIDTH-1:0] i_score,
    input  logic                   i_blank,
    output logic [6:0]             o_segments,
    output logic                   o_digit,
    output logic                   o_frame_start
);

    import score_display_pkg::*;

    localparam int CNT_MAX = (CLKS_PER_DIGIT > BLANK_CLKS) ? CLKS_PER_DIGIT : BLANK_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DIGIT_LOAD = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CLKS - 1);

    state_t           r_state;
    logic [6:0]       r_snap;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_score_ext;
    logic [6:0]       w_score_sat;
    logic [3:0]       w_dec_in;
    logic [6:0]       w_dec_seg;
    logic [6:0]       w_tens_seg;
    logic [6:0]       w_ones_seg;
    logic             w_cnt_done;

    assign w_score_ext = 32'(i_score);
    assign w_score_sat = saturate_score(w_score_ext);
    assign w_cnt_done  = (r_cnt == '0);

    // One decoder serves both digits: the tens value is needed while
    // finishing conversion or holding SCAN_TENS, the ones value otherwise.
    assign w_dec_in = ((r_state == S_CONVERT) || (r_state == S_SCAN_TENS)) ? r_tens : r_ones;

    seg_digit_decoder u_decoder (
        .i_value    (w_dec_in),
        .o_segments (w_dec_seg)
    );

`ifdef SCORE_DISPLAY_LZB_EN
    assign w_tens_seg = (i_blank || (r_tens == 4'd0)) ? SEG_OFF : w_dec_seg;
`else
    assign w_tens_seg = i_blank ? SEG_OFF : w_dec_seg;
`endif
    assign w_ones_seg = i_blank ? SEG_OFF : w_dec_seg;

    // Each branch registers the outputs belonging to the state being
    // entered, so the decoded digit is visible in the first scan cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_LOAD;
            r_snap        <= '0;
            r_tens        <= '0;
            r_ones        <= '0;
            r_cnt         <= '0;
            o_segments    <= SEG_OFF;
            o_digit       <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_snap        <= w_score_sat;
                    r_tens        <= '0;
                    r_state       <= S_CONVERT;
                    o_frame_start <= 1'b1;
                    o_segments    <= SEG_OFF;
                    o_digit       <= 1'b0;
                end
                S_CONVERT: begin
                    o_digit <= 1'b0;
                    if (r_snap >= CONV_STEP) begin
                        r_snap     <= r_snap - CONV_STEP;
                        r_tens     <= r_tens + 4'd1;
                        o_segments <= SEG_OFF;
                    end else begin
                        r_ones     <= r_snap[3:0];
                        r_cnt      <= DIGIT_LOAD;
                        r_state    <= S_SCAN_TENS;
                        o_segments <= w_tens_seg;
                    end
                end
                S_SCAN_TENS: begin
                    o_digit <= 1'b0;
                    if (w_cnt_done) begin
                        r_cnt      <= BLANK_LOAD;
                        r_state    <= S_BLANK_A;
                        o_segments <= SEG_OFF;
                    end else begin
                        r_cnt      <= r_cnt - 1'b1;
                        o_segments <= w_tens_seg;
                    end
                end
                S_BLANK_A: begin
                    if (w_cnt_done) begin
                        r_cnt      <= DIGIT_LOAD;
                        r_state    <= S_SCAN_ONES;
                        o_segments <= w_ones_seg;
                        o_digit    <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt - 1'b1;
                        o_segments <= SEG_OFF;
                        o_digit    <= 1'b0;
                    end
                end
                S_SCAN_ONES: begin
                    o_digit <= 1'b1;
                    if (w_cnt_done) begin
                        r_cnt      <= BLANK_LOAD;
                        r_state    <= S_BLANK_B;
                        o_segments <= SEG_OFF;
                    end else begin
                        r_cnt      <= r_cnt - 1'b1;
                        o_segments <= w_ones_seg;
                    end
                end
                S_BLANK_B: begin
                    o_segments <= SEG_OFF;
                    if (w_cnt_done) begin
                        r_state <= S_LOAD;
                        o_digit <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                        o_digit <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_LOAD;
                    o_segments <= SEG_OFF;
                    o_digit    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_display_scan_controller.sv
// tb/tb_score_display_scan_controller.sv - randomized self-checking bench for the score display scanner
module tb_score_display_scan_controller;

    localparam int CPD = 8;
    localparam int BLK = 2;
    localparam logic [6:0] OFF = 7'h7F;

    localparam int PH_CONV  = 0;
    localparam int PH_TENS  = 1;
    localparam int PH_BLK_A = 2;
    localparam int PH_ONES  = 3;
    localparam int PH_BLK_B = 4;
    localparam int PH_LOAD  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] score = 7'd0;
    logic       blank = 1'b0;
    logic [6:0] seg;
    logic       dig;
    logic       fs;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [6:0] seg;
        logic       dig;
        logic       fs;
        int         ph;
    } ent_t;

    ent_t plan[$];
    ent_t cur;

    always #5 clk = ~clk;

    score_display_scan_controller #(
        .SCORE_WIDTH    (7),
        .CLKS_PER_DIGIT (CPD),
        .BLANK_CLKS     (BLK)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_score       (score),
        .i_blank       (blank),
        .o_segments    (seg),
        .o_digit       (dig),
        .o_frame_start (fs)
    );

    function automatic logic [6:0] pat_of(int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return OFF;
        endcase
    endfunction

    function automatic ent_t mk(logic [6:0] s, logic d, logic f, int p);
        ent_t e;
        e.seg = s;
        e.dig = d;
        e.fs  = f;
        e.ph  = p;
        return e;
    endfunction

    // Expected per-cycle outputs of one whole frame, from the cycle after
    // the snapshot edge up to and including the next LOAD cycle.
    task automatic build_plan(int sc);
        int s, t, o;
        logic [6:0] tp;
        s = (sc > 99) ? 99 : sc;
        t = s / 10;
        o = s % 10;
        tp = pat_of(t);
`ifdef SCORE_DISPLAY_LZB_EN
        if (t == 0) tp = OFF;
`endif
        plan.push_back(mk(OFF, 1'b0, 1'b1, PH_CONV));
        for (int i = 0; i < t; i++) plan.push_back(mk(OFF, 1'b0, 1'b0, PH_CONV));
        for (int i = 0; i < CPD; i++) plan.push_back(mk(tp, 1'b0, 1'b0, PH_TENS));
        for (int i = 0; i < BLK; i++) plan.push_back(mk(OFF, 1'b0, 1'b0, PH_BLK_A));
        for (int i = 0; i < CPD; i++) plan.push_back(mk(pat_of(o), 1'b1, 1'b0, PH_ONES));
        for (int i = 0; i < BLK; i++) plan.push_back(mk(OFF, 1'b1, 1'b0, PH_BLK_B));
        plan.push_back(mk(OFF, 1'b0, 1'b0, PH_LOAD));
    endtask

    // One clock: advance the model on the edge, compare at the falling edge.
    task automatic step(string name);
        logic [6:0] exp_seg;
        @(posedge clk);
        if (plan.size() == 0) build_plan(int'(score));
        cur = plan.pop_front();
        exp_seg = blank ? OFF : cur.seg;
        @(negedge clk);
        total++;
        if (seg !== exp_seg) begin
            bad++;
            $display("FAIL %s segments: got %h want %h (phase %0d)", name, seg, exp_seg, cur.ph);
        end
        total++;
        if (dig !== cur.dig) begin
            bad++;
            $display("FAIL %s digit: got %b want %b (phase %0d)", name, dig, cur.dig, cur.ph);
        end
        total++;
        if (fs !== cur.fs) begin
            bad++;
            $display("FAIL %s frame_start: got %b want %b (phase %0d)", name, fs, cur.fs, cur.ph);
        end
    endtask

    task automatic run_frame(string name);
        int guard;
        guard = 0;
        step(name);
        while (plan.size() > 0 && guard < 200) begin
            step(name);
            guard++;
        end
        total++;
        if (plan.size() != 0) begin
            bad++;
            $display("FAIL %s frame_bound: got %0d left want 0", name, plan.size());
        end
    endtask

    task automatic check_reset_vals(string name);
        total++;
        if (seg !== OFF) begin
            bad++;
            $display("FAIL %s segments: got %h want %h", name, seg, OFF);
        end
        total++;
        if (dig !== 1'b0) begin
            bad++;
            $display("FAIL %s digit: got %b want 0", name, dig);
        end
        total++;
        if (fs !== 1'b0) begin
            bad++;
            $display("FAIL %s frame_start: got %b want 0", name, fs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        score = 7'd0;
        blank = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_hold");
        rst = 1'b0;
        plan.delete();
        run_frame("reset_zero");
    endtask

    task automatic test_score(int sc, string name);
        score = 7'(sc);
        run_frame(name);
    endtask

    task automatic test_change();
        int guard;
        score = 7'd23;
        step("change_23");
        guard = 0;
        while (cur.ph != PH_TENS && guard < 50) begin
            step("change_23");
            guard++;
        end
        step("change_23");
        score = 7'd58;
        while (plan.size() > 0 && guard < 100) begin
            step("change_23");
            guard++;
        end
        run_frame("change_58");
    endtask

    task automatic test_blank();
        score = 7'd36;
        blank = 1'b1;
        run_frame("blank_frame");
        blank = 1'b0;
        run_frame("blank_release");
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            score = 7'($urandom_range(0, 127));
            step("random");
            while (plan.size() > 0) begin
                if ($urandom_range(0, 3) == 0) score = 7'($urandom_range(0, 127));
                blank = ($urandom_range(0, 7) == 0);
                step("random");
            end
            blank = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        int guard;
        score = 7'd64;
        guard = 0;
        step("async_pre");
        while (cur.ph != PH_ONES && guard < 100) begin
            step("async_pre");
            guard++;
        end
        total++;
        if (cur.ph != PH_ONES) begin
            bad++;
            $display("FAIL async_reach_ones: got phase %0d want %0d", cur.ph, PH_ONES);
        end
        #1 rst = 1'b1;
        #1 check_reset_vals("async_reset");
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("async_hold");
        rst = 1'b0;
        plan.delete();
        score = 7'd91;
        run_frame("async_after");
    endtask

    initial begin
        test_reset();
        test_score(47, "score_47");
        test_score(120, "score_120");
        test_score(99, "score_99");
        test_score(5, "score_5");
        test_score(10, "score_10");
        test_change();
        test_blank();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
